// File: rtl/ldiv_pkg.sv
// Shared definitions for the long-division / multiply-add pair.
// Default widths and pipeline alignment helpers.
package ldiv_pkg;

  localparam int LMA_MULTIPLIER_WIDTH   = 23;
  localparam int LMA_MULTIPLICAND_WIDTH = 15;
  localparam int LMA_ADDEND_WIDTH       = 15;
  localparam int LMA_RESULT_WIDTH       = 23;
  localparam int LMA_TAG_WIDTH          = 8;

  // One request at default widths, handy for
  // benches that build operand bundles.
  typedef struct packed {
    logic [LMA_MULTIPLIER_WIDTH-1:0]   mult;
    logic [LMA_MULTIPLICAND_WIDTH-1:0] mcand;
    logic [LMA_ADDEND_WIDTH-1:0]       addend;
    logic [LMA_TAG_WIDTH-1:0]          tag;
  } lmuladd_req_t;

  // Input register plus one stage per multiplier bit.
  function automatic int lmuladd_latency(input int width);
    return width + 1;
  endfunction

endpackage

// File: rtl/lmuladd_stage.sv
// One Horner step of the multiply-add pipeline.
// Doubles the accumulator and adds one partial product.
module lmuladd_stage
  import ldiv_pkg::*;
#(
  parameter int MULTIPLIER_WIDTH   = LMA_MULTIPLIER_WIDTH,
  parameter int MULTIPLICAND_WIDTH = LMA_MULTIPLICAND_WIDTH,
  parameter int ADDEND_WIDTH       = LMA_ADDEND_WIDTH,
  parameter int TAG_WIDTH          = LMA_TAG_WIDTH,
  parameter int ACC_W              = MULTIPLIER_WIDTH
                                   + MULTIPLICAND_WIDTH,
  parameter int BIT_IDX            = MULTIPLIER_WIDTH - 1,
  parameter int ADD_ADDEND         = 0
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          i_en,
  input  logic [MULTIPLIER_WIDTH-1:0]   i_mult,
  input  logic [MULTIPLICAND_WIDTH-1:0] i_mcand,
  input  logic [ADDEND_WIDTH-1:0]       i_addend,
  input  logic [TAG_WIDTH-1:0]          i_tag,
  input  logic                          i_valid,
  input  logic [ACC_W-1:0]              i_acc,
  output logic [MULTIPLIER_WIDTH-1:0]   o_mult,
  output logic [MULTIPLICAND_WIDTH-1:0] o_mcand,
  output logic [ADDEND_WIDTH-1:0]       o_addend,
  output logic [TAG_WIDTH-1:0]          o_tag,
  output logic                          o_valid,
  output logic [ACC_W-1:0]              o_acc
);

  logic [ACC_W-1:0] w_mcand_ext;
  logic [ACC_W-1:0] w_addend_ext;
  logic [ACC_W-1:0] w_pp;
  logic [ACC_W-1:0] w_add;
  logic [ACC_W-1:0] w_acc_nxt;

  assign w_mcand_ext = {
    {(ACC_W-MULTIPLICAND_WIDTH){1'b0}},
    i_mcand
  };

  assign w_addend_ext = {
    {(ACC_W-ADDEND_WIDTH){1'b0}},
    i_addend
  };

  assign w_pp = i_mult[BIT_IDX] ? w_mcand_ext
                                : '0;

  // Only the final step folds in the addend, so
  // the earlier doublings never scale it.
  if (ADD_ADDEND != 0) begin : g_add
    assign w_add = w_addend_ext;
  end else begin : g_noadd
    assign w_add = '0;
  end

  // ACC_W covers the worst case, so no wrap here.
  assign w_acc_nxt = (i_acc << 1) + w_pp + w_add;

  // Advance accumulator and sideband on enable.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      o_mult   <= '0;
      o_mcand  <= '0;
      o_addend <= '0;
      o_tag    <= '0;
      o_valid  <= 1'b0;
      o_acc    <= '0;
    end else if (i_en) begin
      o_mult   <= i_mult;
      o_mcand  <= i_mcand;
      o_addend <= i_addend;
      o_tag    <= i_tag;
      o_valid  <= i_valid;
      o_acc    <= w_acc_nxt;
    end
  end

endmodule

// File: rtl/lmuladd.sv
// Pipelined multiply-accumulate: mult * mcand + addend.
// One multiplier bit retired per stage, MSB first.
module lmuladd
  import ldiv_pkg::*;
#(
  parameter int MULTIPLIER_WIDTH   = LMA_MULTIPLIER_WIDTH,
  parameter int MULTIPLICAND_WIDTH = LMA_MULTIPLICAND_WIDTH,
  parameter int ADDEND_WIDTH       = LMA_ADDEND_WIDTH,
  parameter int RESULT_WIDTH       = LMA_RESULT_WIDTH,
  parameter int TAG_WIDTH          = LMA_TAG_WIDTH
) (
  input  logic                          clk,
  input  logic                          resetb,
  input  logic                          en,
  input  logic [MULTIPLIER_WIDTH-1:0]   multiplier_in,
  input  logic [MULTIPLICAND_WIDTH-1:0] multiplicand_in,
  input  logic [ADDEND_WIDTH-1:0]       addend_in,
  input  logic [TAG_WIDTH-1:0]          tag_in,
  input  logic                          valid_in,
  output logic [RESULT_WIDTH-1:0]       result_out,
  output logic                          overflow_out,
  output logic [TAG_WIDTH-1:0]          tag_out,
  output logic                          valid_out
);

  localparam int MW    = MULTIPLIER_WIDTH;
  localparam int CW    = MULTIPLICAND_WIDTH;
  localparam int AW    = ADDEND_WIDTH;
  localparam int TW    = TAG_WIDTH;
  localparam int RW    = RESULT_WIDTH;
  localparam int ACC_W = MW + CW;

  logic [MW-1:0] r_mult;
  logic [CW-1:0] r_mcand;
  logic [AW-1:0] r_addend;
  logic [TW-1:0] r_tag;
  logic          r_valid;

  // Stage 0: capture the request as presented.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_mult   <= '0;
      r_mcand  <= '0;
      r_addend <= '0;
      r_tag    <= '0;
      r_valid  <= 1'b0;
    end else if (en) begin
      r_mult   <= multiplier_in;
      r_mcand  <= multiplicand_in;
      r_addend <= addend_in;
      r_tag    <= tag_in;
      r_valid  <= valid_in;
    end
  end

  logic [MW-1:0]    w_mult   [0:MW];
  logic [CW-1:0]    w_mcand  [0:MW];
  logic [AW-1:0]    w_addend [0:MW];
  logic [TW-1:0]    w_tag    [0:MW];
  logic             w_valid  [0:MW];
  logic [ACC_W-1:0] w_acc    [0:MW];

  assign w_mult[0]   = r_mult;
  assign w_mcand[0]  = r_mcand;
  assign w_addend[0] = r_addend;
  assign w_tag[0]    = r_tag;
  assign w_valid[0]  = r_valid;
  // Accumulator enters the chain cleared.
  assign w_acc[0]    = '0;

  for (genvar gi = 1; gi <= MW; gi++) begin : g_stage
    lmuladd_stage #(
      .MULTIPLIER_WIDTH   (MW),
      .MULTIPLICAND_WIDTH (CW),
      .ADDEND_WIDTH       (AW),
      .TAG_WIDTH          (TW),
      .ACC_W              (ACC_W),
      .BIT_IDX            (MW - gi),
      .ADD_ADDEND         ((gi == MW) ? 1 : 0)
    ) u_stage (
      .clk      (clk),
      .resetb   (resetb),
      .i_en     (en),
      .i_mult   (w_mult[gi-1]),
      .i_mcand  (w_mcand[gi-1]),
      .i_addend (w_addend[gi-1]),
      .i_tag    (w_tag[gi-1]),
      .i_valid  (w_valid[gi-1]),
      .i_acc    (w_acc[gi-1]),
      .o_mult   (w_mult[gi]),
      .o_mcand  (w_mcand[gi]),
      .o_addend (w_addend[gi]),
      .o_tag    (w_tag[gi]),
      .o_valid  (w_valid[gi]),
      .o_acc    (w_acc[gi])
    );
  end

  assign tag_out   = w_tag[MW];
  assign valid_out = w_valid[MW];

  if (RW < ACC_W) begin : g_ovf
    assign result_out   = w_acc[MW][RW-1:0];
    assign overflow_out = |w_acc[MW][ACC_W-1:RW];
  end else begin : g_noovf
    assign result_out   = RW'(w_acc[MW]);
    assign overflow_out = 1'b0;
  end

  // Operands leaving the last stage are not needed.
  logic w_unused;
  assign w_unused = ^{w_mult[MW],
                      w_mcand[MW],
                      w_addend[MW]};

endmodule

// File: tb/tb_lmuladd.sv
// Scoreboard bench for lmuladd.
// Random and directed requests against an arithmetic model.
module tb_lmuladd;
  import ldiv_pkg::*;

  localparam int MW  = 23;
  localparam int CW  = 15;
  localparam int AW  = 15;
  localparam int RW  = 23;
  localparam int TW  = 8;
  localparam int LAT = lmuladd_latency(MW);

  logic          clk;
  logic          resetb;
  logic          en;
  logic [MW-1:0] multiplier_in;
  logic [CW-1:0] multiplicand_in;
  logic [AW-1:0] addend_in;
  logic [TW-1:0] tag_in;
  logic          valid_in;
  logic [RW-1:0] result_out;
  logic          overflow_out;
  logic [TW-1:0] tag_out;
  logic          valid_out;

  lmuladd #(
    .MULTIPLIER_WIDTH   (MW),
    .MULTIPLICAND_WIDTH (CW),
    .ADDEND_WIDTH       (AW),
    .RESULT_WIDTH       (RW),
    .TAG_WIDTH          (TW)
  ) dut (
    .clk             (clk),
    .resetb          (resetb),
    .en              (en),
    .multiplier_in   (multiplier_in),
    .multiplicand_in (multiplicand_in),
    .addend_in       (addend_in),
    .tag_in          (tag_in),
    .valid_in        (valid_in),
    .result_out      (result_out),
    .overflow_out    (overflow_out),
    .tag_out         (tag_out),
    .valid_out       (valid_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint        due;
    logic [RW-1:0] res;
    logic          ovf;
    logic [TW-1:0] tag;
    bit            seen;
  } exp_t;

  exp_t   sbq[$];
  int     n_checks = 0;
  int     n_pass   = 0;
  longint en_edges = 0;

  task automatic chk(input string name,
                     input logic [63:0] got,
                     input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h at %0t",
                  name, got, want, $time);
  endtask

  // Enabled edges out of reset: the pipeline's own clock.
  always @(posedge clk)
    if (resetb && en) en_edges <= en_edges + 1;

  // Plain arithmetic reference: full product plus addend.
  function automatic exp_t model(input logic [MW-1:0] m,
                                 input logic [CW-1:0] c,
                                 input logic [AW-1:0] a,
                                 input logic [TW-1:0] t,
                                 input longint due);
    exp_t e;
    logic [63:0] full;
    full   = 64'(m) * 64'(c) + 64'(a);
    e.due  = due;
    e.res  = full[RW-1:0];
    e.ovf  = (full >= (64'd1 << RW));
    e.tag  = t;
    e.seen = 1'b0;
    return e;
  endfunction

  task automatic set_op(input logic v,
                        input logic [MW-1:0] m,
                        input logic [CW-1:0] c,
                        input logic [AW-1:0] a,
                        input logic [TW-1:0] t);
    valid_in        = v;
    multiplier_in   = m;
    multiplicand_in = c;
    addend_in       = a;
    tag_in          = t;
  endtask

  // Clock once; if the request was taken, queue its answer.
  task automatic tick(input bit has_ref,
                      input logic [RW-1:0] ref_res,
                      input logic ref_ovf);
    exp_t e;
    @(posedge clk);
    #1;
    if (resetb && en && valid_in) begin
      e = model(multiplier_in, multiplicand_in,
                addend_in, tag_in, en_edges + LAT - 1);
      if (has_ref) begin
        e.res = ref_res;
        e.ovf = ref_ovf;
      end
      sbq.push_back(e);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    en = 1'b1;
    set_op(1'b0, '0, '0, '0, '0);
    while (sbq.size() > 0 && k < 200) begin
      tick(1'b0, '0, 1'b0);
      k++;
    end
    chk("drain_left", 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  function automatic logic [63:0] pick(input int w);
    logic [63:0] r;
    int sel;
    sel = $urandom_range(0, 5);
    r   = {$urandom, $urandom};
    if (sel == 0) return 64'd0;
    if (sel == 1) return (64'd1 << w) - 1;
    return r & ((64'd1 << w) - 1);
  endfunction

  // Monitor: pop overdue entries, compare what is showing.
  always @(negedge clk) begin
    bit ev;
    while (sbq.size() > 0 && sbq[0].due < en_edges) begin
      if (!sbq[0].seen) begin
        n_checks++;
        $display("FAIL missing_output: tag 0x%0h got none want one",
                 sbq[0].tag);
      end
      void'(sbq.pop_front());
    end
    ev = (sbq.size() > 0) && (sbq[0].due == en_edges);
    chk("valid_out", 64'(valid_out), 64'(ev));
    if (ev && valid_out) begin
      chk("result_out", 64'(result_out), 64'(sbq[0].res));
      chk("overflow_out", 64'(overflow_out), 64'(sbq[0].ovf));
      chk("tag_out", 64'(tag_out), 64'(sbq[0].tag));
      sbq[0].seen = 1'b1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [MW-1:0] n, q;
    logic [CW-1:0] d;
    logic [AW-1:0] r;
    lmuladd_req_t  req;

    resetb = 1'b0;
    en     = 1'b0;
    set_op(1'b0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", 64'(result_out), 64'd0);
    chk("rst_ovf", 64'(overflow_out), 64'd0);
    chk("rst_tag", 64'(tag_out), 64'd0);
    chk("rst_valid", 64'(valid_out), 64'd0);
    resetb = 1'b1;
    en     = 1'b1;

    // Directed cases with hand-computed answers.
    set_op(1'b1, 23'd1000, 15'd7, 15'd5, 8'h11);
    tick(1'b1, 23'd7005, 1'b0);
    drain();
    set_op(1'b1, 23'h7FFFFF, 15'h7FFF, 15'd0, 8'h22);
    tick(1'b1, 23'd8355841, 1'b1);
    set_op(1'b1, 23'd0, 15'h7FFF, 15'd9, 8'h33);
    tick(1'b1, 23'd9, 1'b0);
    set_op(1'b1, 23'h7FFFFF, 15'd0, 15'h7FFF, 8'h44);
    tick(1'b1, 23'h7FFF, 1'b0);
    drain();

    // Divider round trip: q*d + r must rebuild n.
    for (int i = 0; i < 30; i++) begin
      n = MW'($urandom);
      d = CW'($urandom_range(1, 32767));
      q = n / MW'(d);
      r = AW'(n % MW'(d));
      set_op(1'b1, q, d, r, TW'(i));
      tick(1'b1, n, 1'b0);
    end
    drain();

    // Stall with ops in flight, then again mid-output.
    for (int i = 0; i < 10; i++) begin
      set_op(1'b1, MW'(pick(MW)), CW'(pick(CW)),
             AW'(pick(AW)), TW'(8'h40 + i));
      tick(1'b0, '0, 1'b0);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_op(1'b1, MW'($urandom), CW'($urandom),
             AW'($urandom), 8'hEE);
      tick(1'b0, '0, 1'b0);
    end
    en = 1'b1;
    set_op(1'b0, '0, '0, '0, '0);
    repeat (16) tick(1'b0, '0, 1'b0);
    en = 1'b0;
    set_op(1'b1, '1, '1, '1, 8'hEF);
    repeat (3) tick(1'b0, '0, 1'b0);
    drain();

    // Random traffic with random enable.
    for (int i = 0; i < 300; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      req     = '{mult:   MW'(pick(MW)),
                  mcand:  CW'(pick(CW)),
                  addend: AW'(pick(AW)),
                  tag:    TW'($urandom)};
      set_op(($urandom_range(0, 9) < 7), req.mult,
             req.mcand, req.addend, req.tag);
      tick(1'b0, '0, 1'b0);
    end
    drain();

    // Reset with 12 operations in flight.
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_op(1'b1, MW'(pick(MW)), CW'(pick(CW)) | 15'd1,
             AW'(pick(AW)), TW'(8'h80 + i));
      tick(1'b0, '0, 1'b0);
    end
    set_op(1'b0, '0, '0, '0, '0);
    repeat (8) tick(1'b0, '0, 1'b0);
    #2;
    resetb = 1'b0;
    sbq.delete();
    #1;
    chk("async_valid", 64'(valid_out), 64'd0);
    chk("async_result", 64'(result_out), 64'd0);
    chk("async_tag", 64'(tag_out), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    resetb = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(valid_out), 64'd0);
      chk("post_rst_result", 64'(result_out), 64'd0);
      chk("post_rst_ovf", 64'(overflow_out), 64'd0);
      chk("post_rst_tag", 64'(tag_out), 64'd0);
    end
    @(posedge clk);
    #1;
    chk("final_queue", 64'(sbq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lmuladd.md
# lmuladd

Pipelined shift-add multiply-accumulator computing `result = multiplier * multiplicand + addend`, the inverse of the long-division pipeline (`quotient * denominator + remainder = numerator`). It retires one multiplier bit per stage, MSB first, and accepts a new operation every enabled cycle. It sits beside the divider as its reconstruction path: the divider bench and the datapath feed quotient/denominator/remainder back through it to recover and check the numerator. A tag travels with each operation so results can be matched to requests.

## Interface
- `MULTIPLIER_WIDTH`, 23: multiplier bits; also the number of Horner stages.
- `MULTIPLICAND_WIDTH`, 15: multiplicand bits.
- `ADDEND_WIDTH`, 15: addend bits; must be ≤ max(MULTIPLIER_WIDTH, MULTIPLICAND_WIDTH).
- `RESULT_WIDTH`, 23: output width; higher bits are reported through `overflow_out`.
- `TAG_WIDTH`, 8: opaque tag carried with each operation.

Ports:
- `clk`  in  1  clock.
- `resetb`  in  1  reset; asynchronous, active-low.
- `en`  in  1  pipeline advance enable; low freezes every stage.
- `multiplier_in`  in  MULTIPLIER_WIDTH  multiplier.
- `multiplicand_in`  in  MULTIPLICAND_WIDTH  multiplicand.
- `addend_in`  in  ADDEND_WIDTH  addend.
- `tag_in`  in  TAG_WIDTH  request tag.
- `valid_in`  in  1  operation present; sampled only when `en`=1.
- `result_out`  out  RESULT_WIDTH  low RESULT_WIDTH bits of the full sum.
- `overflow_out`  out  1  full sum ≥ 2^RESULT_WIDTH.
- `tag_out`  out  TAG_WIDTH  tag of the emerging operation.
- `valid_out`  out  1  outputs valid this cycle.

## Operation
- Internal accumulator width is `ACC_W = MULTIPLIER_WIDTH + MULTIPLICAND_WIDTH`. The full sum always fits: (2^A−1)(2^B−1) + 2^C − 1 < 2^(A+B) for C ≤ max(A,B).
- Stage 0 registers the inputs and clears the accumulator to 0.
- Stage i, for i = 1..MULTIPLIER_WIDTH, computes acc_i = (acc_{i−1} << 1) + (multiplier[MULTIPLIER_WIDTH−i] ? multiplicand : 0).
- The last stage also adds the zero-extended addend in the same cycle.
- Multiplicand, addend, tag and valid are forwarded unchanged stage to stage.
- The multiplier is forwarded along with them; shifting it is an implementation choice.
- Final stage:
  - `result_out` = acc[RESULT_WIDTH−1:0].
  - `overflow_out` = |acc[ACC_W−1:RESULT_WIDTH]`; tie it to 0 when RESULT_WIDTH ≥ ACC_W.
- Stages hold data regardless of valid. `result_out`, `overflow_out` and `tag_out` are meaningful only while `valid_out`=1.
- There is no backpressure output. Upstream owns `en`.

## Timing
- Reset (async assert; release synchronous to `clk`): every stage register clears. All outputs read 0: `result_out`, `overflow_out`, `tag_out`, `valid_out`.
- Latency: MULTIPLIER_WIDTH+1 enabled cycles (24 at defaults).
  - An operation sampled at rising edge k with `en`=1 appears on the outputs after the edge at which the (MULTIPLIER_WIDTH+1)-th enabled edge has occurred.
- Throughput: one operation per enabled cycle. Ordering is strictly FIFO.
- `en`=0: no register changes. Outputs, including `valid_out`, hold their values. `valid_in` is ignored.
- Reset mid-flight: all in-flight operations are discarded. `valid_out` drops asynchronously. No stale result emerges after release.
- Boundary cases:
  - multiplier=0 gives result=addend.
  - multiplicand=0 gives result=addend.
  - An all-ones operand produces no internal wrap, because ACC_W is sized for the worst case.

## Structure
- Shared package `ldiv_pkg` holds:
  - function `lmuladd_latency(width)` returning width+1, shared with the divider so benches align pipelines;
  - default width localparams (23/15/15/23).
- Sub-module `lmuladd_stage`: one Horner step plus sideband forwarding, with parameter `ADD_ADDEND` enabled on the last stage only.
- The top instantiates stage 0 inline, plus MULTIPLIER_WIDTH generated `lmuladd_stage` instances.

## Test plan
- Basic operation:
  - Stimulus: multiplier=1000, multiplicand=7, addend=5, tag=0x11, `en`=1.
  - Response: exactly 24 cycles later, result=7005, overflow=0, tag=0x11, `valid_out` high for 1 cycle.
- Worst-case operands:
  - Stimulus: multiplier=0x7FFFFF, multiplicand=0x7FFF, addend=0.
  - Response: result=8355841 (low 23 bits), overflow=1.
- Zero multiplier:
  - Stimulus: multiplier=0, multiplicand=0x7FFF, addend=9.
  - Response: result=9, overflow=0.
- Back-to-back round trip:
  - Stimulus: 30 consecutive random divider triples (q, d, r with r<d, q=n/d), tags 0..29.
  - Response: 30 contiguous valid outputs, tags in order, each result=n, overflow=0.
- Stall:
  - Stimulus: 10 operations in flight, then `en` low for 5 cycles.
  - Response: every output arrives exactly 5 cycles later than unstalled, with no duplicates and no drops. Outputs hold during the stall.
- Reset mid-flight:
  - Stimulus: `resetb` asserted with 12 operations in flight, released 3 cycles later, no new inputs.
  - Response: `valid_out` is 0 immediately and stays 0 for 40 cycles. All outputs are 0.
